// File: rtl/tile_command_issuer_pkg.sv
// Shared opcode encoding between the tile command issuer and the matrix controller.
package tile_command_issuer_pkg;

  typedef enum logic [2:0] {
    eNOP       = 3'd0,
    eNewTile   = 3'd1,
    eRotate    = 3'd2,
    eMoveLeft  = 3'd3,
    eMoveRight = 3'd4,
    eMoveDown  = 3'd5
  } tile_opcode_e;

endpackage

// File: rtl/tile_command_issuer.sv
// Tile opcode initiator: turns player buttons, a gravity timer and controller
// feedback into one opcode at a time on a valid/ready handshake, and supplies
// the pseudo-random shape index for each new tile.
module tile_command_issuer
  import tile_command_issuer_pkg::*;
#(
  parameter int unsigned height_p         = 24,
  parameter int unsigned gravity_period_p = 25000000,
  parameter int unsigned das_p            = 8000000,
  parameter int unsigned arr_p            = 2000000
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         btn_left_i,
  input  logic         btn_right_i,
  input  logic         btn_rotate_i,
  input  logic         btn_drop_i,
  input  logic         ready_i,
  input  logic         landed_i,
  input  logic         fail_i,
  output tile_opcode_e opcode_o,
  output logic [7:0]   opcode_op_o,
  output logic         op_v_o
);

  localparam int unsigned GravW   = $clog2(gravity_period_p);
  localparam int unsigned HoldMax = (das_p > arr_p) ? das_p : arr_p;
  localparam int unsigned HoldW   = $clog2(HoldMax + 1);
  localparam int unsigned NumPend = 6;

  // Pending-flag bit positions
  localparam int unsigned PNew   = 0;
  localparam int unsigned PDrop  = 1;
  localparam int unsigned PRot   = 2;
  localparam int unsigned PLeft  = 3;
  localparam int unsigned PRight = 4;
  localparam int unsigned PGrav  = 5;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_FAIL  = 3'd4;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  // Registers
  logic [2:0]         r_state;
  logic               r_op_v;
  tile_opcode_e       r_opcode;
  logic [7:0]         r_arg;
  logic [NumPend-1:0] r_sel;
  logic               r_wait_arm;
  logic [NumPend-1:0] r_pend;
  logic [3:0]         r_prev_btn;
  logic [HoldW-1:0]   r_hold_cnt [2];
  logic [GravW-1:0]   r_grav_cnt;
  logic [15:0]        r_lfsr;

  // Combinational signals
  logic               w_live;
  logic [3:0]         w_btn;
  logic [3:0]         w_btn_edge;
  logic [1:0]         w_lr_rep;
  logic [HoldW-1:0]   w_hold_nxt [2];
  logic               w_grav_hit;
  logic               w_accept;
  logic [GravW-1:0]   w_grav_nxt;
  logic [NumPend-1:0] w_pend_set;
  logic [NumPend-1:0] w_pend_clr;
  logic [NumPend-1:0] w_pend_nxt;
  logic [15:0]        w_lfsr_nxt;
  logic [7:0]         w_tile_arg;
  logic               w_win_valid;
  tile_opcode_e       w_win_opcode;
  logic [7:0]         w_win_arg;
  logic [NumPend-1:0] w_win_sel;
  logic               w_lr_cancel;
  logic [2:0]         w_state_nxt;
  logic               w_op_v_nxt;
  tile_opcode_e       w_opcode_nxt;
  logic [7:0]         w_arg_nxt;
  logic [NumPend-1:0] w_sel_nxt;
  logic               w_wait_arm_nxt;

  assign opcode_o    = r_opcode;
  assign opcode_op_o = r_arg;
  assign op_v_o      = r_op_v;

  assign w_live     = (r_state != ST_FAIL);
  assign w_btn      = {btn_drop_i, btn_rotate_i, btn_right_i, btn_left_i};
  assign w_btn_edge = w_btn & ~r_prev_btn;
  assign w_accept   = (r_state == ST_ISSUE) & ready_i;
  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LfsrTaps : 16'h0000);
  assign w_tile_arg = {5'b0, (r_lfsr[2:0] == 3'd7) ? 3'd0 : r_lfsr[2:0]};

  // Left/right hold counters: delayed auto-start, then fixed-rate repeat
  always_comb begin
    w_lr_rep = '0;
    for (int i = 0; i < 2; i++) begin
      w_hold_nxt[i] = r_hold_cnt[i];
      if (!w_btn[i]) begin
        w_hold_nxt[i] = '0;
      end else if (w_btn_edge[i]) begin
        w_hold_nxt[i] = HoldW'(das_p);
      end else if (r_hold_cnt[i] <= HoldW'(1)) begin
        w_lr_rep[i]   = 1'b1;
        w_hold_nxt[i] = HoldW'(arr_p);
      end else begin
        w_hold_nxt[i] = r_hold_cnt[i] - HoldW'(1);
      end
    end
  end

  // Gravity timer; restarted whenever the tile moves down or a new tile lands
  always_comb begin
    w_grav_hit = (r_grav_cnt == GravW'(gravity_period_p - 1));
    w_grav_nxt = r_grav_cnt + GravW'(1);
    if (w_accept && (r_opcode == eMoveDown || r_opcode == eNewTile)) begin
      w_grav_nxt = '0;
    end else if (w_grav_hit) begin
      w_grav_nxt = '0;
    end
  end

  // Event capture into pending flags; a new event wins over a same-cycle clear
  always_comb begin
    w_pend_set         = '0;
    w_pend_set[PNew]   = landed_i;
    w_pend_set[PDrop]  = w_btn_edge[3];
    w_pend_set[PRot]   = w_btn_edge[2];
    w_pend_set[PLeft]  = w_btn_edge[0] | w_lr_rep[0];
    w_pend_set[PRight] = w_btn_edge[1] | w_lr_rep[1];
    w_pend_set[PGrav]  = w_grav_hit;
    w_pend_nxt         = (r_pend & ~w_pend_clr) | w_pend_set;
  end

  // Priority arbitration over pending flags; opposing left/right cancel out
  always_comb begin
    w_win_valid  = 1'b1;
    w_win_opcode = eNOP;
    w_win_arg    = '0;
    w_win_sel    = '0;
    w_lr_cancel  = 1'b0;
    if (r_pend[PNew]) begin
      w_win_opcode    = eNewTile;
      w_win_arg       = w_tile_arg;
      w_win_sel[PNew] = 1'b1;
    end else if (r_pend[PDrop]) begin
      w_win_opcode     = eMoveDown;
      w_win_arg        = 8'(height_p);
      w_win_sel[PDrop] = 1'b1;
    end else if (r_pend[PRot]) begin
      w_win_opcode    = eRotate;
      w_win_arg       = 8'd1;
      w_win_sel[PRot] = 1'b1;
    end else begin
      w_lr_cancel = r_pend[PLeft] & r_pend[PRight];
      if (r_pend[PLeft] && !r_pend[PRight]) begin
        w_win_opcode     = eMoveLeft;
        w_win_arg        = 8'd1;
        w_win_sel[PLeft] = 1'b1;
      end else if (r_pend[PRight] && !r_pend[PLeft]) begin
        w_win_opcode      = eMoveRight;
        w_win_arg         = 8'd1;
        w_win_sel[PRight] = 1'b1;
      end else if (r_pend[PGrav]) begin
        w_win_opcode     = eMoveDown;
        w_win_arg        = 8'd1;
        w_win_sel[PGrav] = 1'b1;
      end else begin
        w_win_valid = 1'b0;
      end
    end
  end

  // FSM next-state and registered-output values
  always_comb begin
    w_state_nxt    = r_state;
    w_op_v_nxt     = r_op_v;
    w_opcode_nxt   = r_opcode;
    w_arg_nxt      = r_arg;
    w_sel_nxt      = r_sel;
    w_wait_arm_nxt = r_wait_arm;
    w_pend_clr     = '0;
    case (r_state)
      ST_INIT: begin
        w_state_nxt  = ST_ISSUE;
        w_op_v_nxt   = 1'b1;
        w_opcode_nxt = eNewTile;
        w_arg_nxt    = w_tile_arg;
        w_sel_nxt    = '0;
      end
      ST_IDLE: begin
        if (w_lr_cancel) begin
          w_pend_clr[PLeft]  = 1'b1;
          w_pend_clr[PRight] = 1'b1;
        end
        if (w_win_valid) begin
          w_state_nxt  = ST_ISSUE;
          w_op_v_nxt   = 1'b1;
          w_opcode_nxt = w_win_opcode;
          w_arg_nxt    = w_win_arg;
          w_sel_nxt    = w_win_sel;
        end
      end
      ST_ISSUE: begin
        if (ready_i) begin
          w_state_nxt    = ST_WAIT;
          w_op_v_nxt     = 1'b0;
          w_pend_clr     = r_sel;
          w_wait_arm_nxt = 1'b0;
        end
      end
      ST_WAIT: begin
        w_wait_arm_nxt = 1'b1;
        if (r_wait_arm && ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FAIL: begin
        w_op_v_nxt   = 1'b0;
        w_opcode_nxt = eNOP;
        w_arg_nxt    = '0;
      end
      default: begin
        w_state_nxt  = ST_INIT;
        w_op_v_nxt   = 1'b0;
        w_opcode_nxt = eNOP;
        w_arg_nxt    = '0;
      end
    endcase
    if (fail_i) begin
      w_state_nxt  = ST_FAIL;
      w_op_v_nxt   = 1'b0;
      w_opcode_nxt = eNOP;
      w_arg_nxt    = '0;
      w_sel_nxt    = '0;
      w_pend_clr   = '0;
    end
  end

  // FSM state and output registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= ST_INIT;
      r_op_v     <= 1'b0;
      r_opcode   <= eNOP;
      r_arg      <= '0;
      r_sel      <= '0;
      r_wait_arm <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_op_v     <= w_op_v_nxt;
      r_opcode   <= w_opcode_nxt;
      r_arg      <= w_arg_nxt;
      r_sel      <= w_sel_nxt;
      r_wait_arm <= w_wait_arm_nxt;
    end
  end

  // Event-capture state; frozen in the fail state except the free-running LFSR
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_prev_btn    <= '0;
      r_hold_cnt[0] <= '0;
      r_hold_cnt[1] <= '0;
      r_grav_cnt    <= '0;
      r_pend        <= '0;
      r_lfsr        <= LfsrSeed;
    end else begin
      r_lfsr <= w_lfsr_nxt;
      if (w_live) begin
        r_prev_btn    <= w_btn;
        r_hold_cnt[0] <= w_hold_nxt[0];
        r_hold_cnt[1] <= w_hold_nxt[1];
        r_grav_cnt    <= w_grav_nxt;
        r_pend        <= w_pend_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tile_command_issuer.sv
// Directed bench for tile_command_issuer: a per-cycle vector table for the
// handshake/priority/cancel behaviour, then hand-written sequences for
// gravity restart, auto-repeat timing, landed priority, fail and reset.
module tb_tile_command_issuer;
  import tile_command_issuer_pkg::*;

  typedef struct {
    logic         left;
    logic         right;
    logic         rot;
    logic         drop;
    logic         ready;
    logic         exp_v;
    tile_opcode_e exp_op;
    int           exp_arg;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         btn_left, btn_right, btn_rotate, btn_drop;
  logic         ready, landed, fail;
  tile_opcode_e opcode;
  logic [7:0]   op_arg;
  logic         op_v;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  vec_t vecs[$];

  tile_command_issuer #(
    .height_p         (24),
    .gravity_period_p (1000),
    .das_p            (4),
    .arr_p            (2)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .btn_left_i   (btn_left),
    .btn_right_i  (btn_right),
    .btn_rotate_i (btn_rotate),
    .btn_drop_i   (btn_drop),
    .ready_i      (ready),
    .landed_i     (landed),
    .fail_i       (fail),
    .opcode_o     (opcode),
    .opcode_op_o  (op_arg),
    .op_v_o       (op_v)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int max_cyc, output int vcyc);
    int n;
    n    = 0;
    vcyc = -1;
    while (!op_v && n < max_cyc) begin
      step();
      n++;
    end
    if (op_v) begin
      vcyc = cyc;
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: op_v not seen within %0d cycles", name, max_cyc);
    end
  endtask

  task automatic add_vec(input logic l, input logic r, input logic ro, input logic dr,
                         input logic rdy, input logic ev, input tile_opcode_e op,
                         input int arg);
    vec_t v;
    v.left = l; v.right = r; v.rot = ro; v.drop = dr; v.ready = rdy;
    v.exp_v = ev; v.exp_op = op; v.exp_arg = arg;
    vecs.push_back(v);
  endtask

  initial begin
    int drop_acc;
    int d_acc;
    int vc;
    int offs[$];
    int exp_offs[4];
    logic prev_v;

    // Per-cycle table: inputs for the cycle, expected outputs after the edge
    add_vec(0,0,0,0,1, 1, eNewTile, 1);   // first tile straight out of init
    add_vec(0,0,0,0,1, 0, eNOP, 0);       // accepted
    add_vec(0,0,0,0,1, 0, eNOP, 0);       // wait, ready ignored
    add_vec(0,0,0,0,1, 0, eNOP, 0);       // back to idle
    add_vec(0,0,1,1,1, 0, eNOP, 0);       // drop + rotate edges captured
    add_vec(0,0,1,1,1, 1, eMoveDown, 24); // drop wins
    add_vec(0,0,1,1,1, 0, eNOP, 0);       // accepted (index 6)
    add_vec(0,0,0,0,1, 0, eNOP, 0);
    add_vec(0,0,0,0,1, 0, eNOP, 0);
    add_vec(0,0,0,0,1, 1, eRotate, 1);    // rotate was kept pending
    add_vec(0,0,0,0,1, 0, eNOP, 0);
    add_vec(0,0,0,0,1, 0, eNOP, 0);
    add_vec(0,0,0,0,1, 0, eNOP, 0);
    add_vec(0,0,1,0,0, 0, eNOP, 0);       // rotate edge, ready low
    add_vec(0,0,0,0,0, 1, eRotate, 1);
    add_vec(1,0,0,0,0, 1, eRotate, 1);    // left edge during stall
    add_vec(0,1,0,0,0, 1, eRotate, 1);    // right edge during stall
    for (int k = 0; k < 5; k++) add_vec(0,0,0,0,0, 1, eRotate, 1);
    add_vec(0,0,0,0,1, 0, eNOP, 0);       // accepted
    for (int k = 0; k < 7; k++) add_vec(0,0,0,0,1, 0, eNOP, 0); // left/right cancelled

    drop_acc = 0;
    rst = 1'b1;
    btn_left = 0; btn_right = 0; btn_rotate = 0; btn_drop = 0;
    ready = 0; landed = 0; fail = 0;
    repeat (3) step();
    chk("reset_op_v", int'(op_v), 0);
    chk("reset_opcode", int'(opcode), int'(eNOP));
    chk("reset_arg", int'(op_arg), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      btn_left = vecs[i].left; btn_right = vecs[i].right;
      btn_rotate = vecs[i].rot; btn_drop = vecs[i].drop;
      ready = vecs[i].ready;
      step();
      chk($sformatf("vec%0d_op_v", i), int'(op_v), int'(vecs[i].exp_v));
      if (vecs[i].exp_v) begin
        chk($sformatf("vec%0d_opcode", i), int'(opcode), int'(vecs[i].exp_op));
        chk($sformatf("vec%0d_arg", i), int'(op_arg), vecs[i].exp_arg);
      end
      if (i == 6) drop_acc = cyc;
    end

    // Gravity: period counted from the last accepted drop
    ready = 1;
    wait_valid("grav1_wait", 1100, vc);
    chk("grav1_cycle", vc, drop_acc + 1001);
    chk("grav1_opcode", int'(opcode), int'(eMoveDown));
    chk("grav1_arg", int'(op_arg), 1);
    step();
    chk("grav1_accept", int'(op_v), 0);
    repeat (500) step();
    btn_drop = 1;
    step();
    btn_drop = 0;
    wait_valid("middrop_wait", 10, vc);
    chk("middrop_opcode", int'(opcode), int'(eMoveDown));
    chk("middrop_arg", int'(op_arg), 24);
    d_acc = vc + 1;
    step();
    wait_valid("grav2_wait", 1100, vc);
    chk("grav2_cycle", vc, d_acc + 1001);
    chk("grav2_opcode", int'(opcode), int'(eMoveDown));
    chk("grav2_arg", int'(op_arg), 1);
    step();
    repeat (5) step();

    // Left auto-repeat: held for 12 edges
    exp_offs = '{1, 5, 9, 13};
    prev_v = op_v;
    btn_left = 1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (op_v && !prev_v) begin
        offs.push_back(i);
        chk("left_opcode", int'(opcode), int'(eMoveLeft));
        chk("left_arg", int'(op_arg), 1);
      end
      prev_v = op_v;
      if (i == 11) btn_left = 0;
    end
    chk("left_count", offs.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("left_issue%0d_offset", k), (k < offs.size()) ? offs[k] : -1, exp_offs[k]);
    end
    repeat (3) step();

    // Landed with rotate pending: new tile first
    btn_rotate = 1; landed = 1;
    step();
    btn_rotate = 0; landed = 0;
    wait_valid("landed_wait", 10, vc);
    chk("landed_opcode", int'(opcode), int'(eNewTile));
    checks++;
    if (op_arg > 8'd6) begin
      errors++;
      $display("FAIL landed_tile_range: got %0d expected 0..6", op_arg);
    end
    step();
    wait_valid("rot_after_new_wait", 10, vc);
    chk("rot_after_new_opcode", int'(opcode), int'(eRotate));
    chk("rot_after_new_arg", int'(op_arg), 1);
    step();
    repeat (3) step();

    // Fail while holding an opcode, then stimulus must be ignored
    ready = 0;
    btn_rotate = 1;
    step();
    btn_rotate = 0;
    wait_valid("prefail_wait", 10, vc);
    step();
    chk("prefail_held", int'(op_v), 1);
    fail = 1;
    step();
    chk("fail_op_v", int'(op_v), 0);
    chk("fail_opcode", int'(opcode), int'(eNOP));
    ready = 1;
    for (int i = 0; i < 16; i++) begin
      btn_left = i[0]; btn_drop = i[1]; landed = i[2]; btn_rotate = i[3];
      step();
      chk($sformatf("fail_quiet%0d", i), int'(op_v), 0);
    end

    // Reset recovers; reset mid-handshake drops valid without a clock edge
    rst = 1;
    fail = 0; btn_left = 0; btn_drop = 0; landed = 0; btn_rotate = 0; ready = 0;
    step();
    rst = 0;
    step();
    chk("rerun_op_v", int'(op_v), 1);
    chk("rerun_opcode", int'(opcode), int'(eNewTile));
    chk("rerun_arg", int'(op_arg), 1);
    repeat (3) step();
    chk("rerun_stall_op_v", int'(op_v), 1);
    chk("rerun_stall_opcode", int'(opcode), int'(eNewTile));
    #2;
    rst = 1;
    #1;
    chk("async_reset_op_v", int'(op_v), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
